rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one downstream resource among eight requesters. Each cycle with no active grant it picks the next requesting port after the most recently served one and holds that grant until the holder drops its request or a hold-time limit expires. It sits in front of the shared 3-bit-coded datapath and drives both a one-hot grant vector and the encoded 3-bit winner index.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/prio_enc8_masked.sv | 34 +++
 rtl/rr_arbiter8.sv | 108 ++++++++++
 tb/tb_rr_arbiter8.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg -- shared widths, FSM state type and one-hot helper for rr_arbiter8
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

    localparam int ARB_N   = 8;
    localparam int ARB_IDW = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [ARB_N-1:0] onehot8(input logic [ARB_IDW-1:0] idx);
        logic [ARB_N-1:0] one;
        one = {{(ARB_N-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc8_masked.sv
// ---------------------------------------------------------------------------
// prio_enc8_masked -- first set request at or after ptr, wrapping mod 8
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prio_enc8_masked
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]   req,
    input  logic [ARB_IDW-1:0] ptr,
    output logic               any,
    output logic [ARB_IDW-1:0] idx
);

    logic [ARB_N-1:0]   rot;
    logic [ARB_IDW-1:0] enc;

    always_comb begin
        // Rotating right puts requester ptr at bit 0, so lowest-first is round-robin.
        rot = ARB_N'({req, req} >> ptr);
        enc = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = ARB_IDW'(i);
            end
        end
        any = |req;
        idx = enc + ptr;
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8 -- 8-way round-robin arbiter with hold-time limit, registered outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ARB_N-1:0]   req,
    output logic [ARB_N-1:0]   gnt,
    output logic [ARB_IDW-1:0] gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int                CNT_W      = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  C_MAX_HOLD = CNT_W'(MAX_HOLD);

    arb_state_t         state_q,     state_d;
    logic [ARB_IDW-1:0] ptr_q,       ptr_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [ARB_N-1:0]   gnt_q,       gnt_d;
    logic [ARB_IDW-1:0] gnt_id_q,    gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q,   timeout_d;

    logic               win_any;
    logic [ARB_IDW-1:0] win_idx;

    prio_enc8_masked u_enc (
        .req (req),
        .ptr (ptr_q),
        .any (win_any),
        .idx (win_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d     = BUSY;
                    gnt_d       = onehot8(win_idx);
                    gnt_id_d    = win_idx;
                    gnt_valid_d = 1'b1;
                    cnt_d       = CNT_W'(1);
                    ptr_d       = win_idx + ARB_IDW'(1);
                end
            end
            BUSY: begin
                // Release by the holder takes priority over the hold-limit revoke.
                if (!req[gnt_id_q] || (cnt_q == C_MAX_HOLD)) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    timeout_d   = req[gnt_id_q];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8 -- scoreboard bench for rr_arbiter8 (MAX_HOLD = 4)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [12:0] exp_q[$];
    int          grant_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: who holds the resource, for how long, and where the scan starts next.
    bit m_busy   = 1'b0;
    int m_holder = 0;
    int m_next   = 0;
    int m_held   = 0;

    always @(posedge clk) begin
        logic [7:0] e_gnt;
        logic [7:0] one;
        logic [2:0] e_id;
        logic       e_v;
        logic       e_t;
        one   = 8'd1;
        e_gnt = 8'h00;
        e_id  = 3'd0;
        e_v   = 1'b0;
        e_t   = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_next = 0;
            m_held = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && req[(m_next + k) % 8]) begin
                    m_busy   = 1'b1;
                    m_holder = (m_next + k) % 8;
                    m_held   = 1;
                end
            end
            if (m_busy) m_next = (m_holder + 1) % 8;
        end else if (!req[m_holder]) begin
            m_busy = 1'b0;
        end else if (m_held == HOLD) begin
            m_busy = 1'b0;
            e_t    = 1'b1;
        end else begin
            m_held++;
        end
        if (m_busy) begin
            e_gnt = one << m_holder;
            e_id  = 3'(m_holder);
            e_v   = 1'b1;
        end
        exp_q.push_back({e_gnt, e_id, e_v, e_t});
    end

    logic prev_v = 1'b0;

    always @(negedge clk) begin
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs{gnt,id,valid,timeout}", {gnt, gnt_id, gnt_valid, timeout}, e);
            if (gnt_valid && !prev_v) grant_log.push_back(int'(gnt_id));
            prev_v = gnt_valid;
        end
    end

    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        #1 req = v;
    endtask

    task automatic wait_grant();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (gnt_valid) break;
        end
        check("grant_appears", gnt_valid, 1'b1);
    endtask

    // Raise v, hold the grant for 'hold' cycles, then the holder drops out and req clears.
    task automatic serve(input logic [7:0] v, input int hold);
        logic [7:0] one;
        one = 8'd1;
        drive(v);
        wait_grant();
        repeat (hold - 1) @(negedge clk);
        #1 req = v & ~(one << gnt_id);
        drive(8'h00);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Basic grant and release
        drive(8'h04);
        wait_grant();
        check("basic_gnt", gnt, 8'h04);
        check("basic_id", gnt_id, 3'd2);
        @(negedge clk);
        #1 req = 8'h00;
        @(negedge clk);
        #1 check("basic_release_gnt", gnt, 8'h00);

        // Rotation from a fresh pointer
        pulse_reset();
        grant_log.delete();
        for (int i = 0; i < 9; i++) serve(8'hFF, 2);
        check("rotation_count", grant_log.size(), 9);
        for (int i = 0; i < 9; i++) check("rotation_order", grant_log[i], i % 8);

        // Wrap-around 7 -> 0 -> 7
        grant_log.delete();
        serve(8'h80, 2);
        serve(8'h81, 2);
        serve(8'h81, 2);
        check("wrap_count", grant_log.size(), 3);
        check("wrap_first", grant_log[0], 7);
        check("wrap_second", grant_log[1], 0);
        check("wrap_third", grant_log[2], 7);

        // Hold-limit revoke: 3 holds forever, 5 waits
        drive(8'h28);
        wait_grant();
        check("timeout_first_id", gnt_id, 3'd3);
        n = 1;
        while (gnt_valid && n < 20) begin
            @(negedge clk);
            #1;
            if (gnt_valid) n++;
        end
        check("timeout_hold_cycles", n, HOLD);
        check("timeout_pulse", timeout, 1'b1);
        wait_grant();
        check("timeout_next_id", gnt_id, 3'd5);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // No preemption while 6 holds
        drive(8'h40);
        wait_grant();
        check("nopreempt_first", gnt_id, 3'd6);
        #1 req = 8'h42;
        @(negedge clk);
        #1 check("nopreempt_hold", gnt_id, 3'd6);
        req = 8'h02;
        wait_grant();
        check("nopreempt_next", gnt_id, 3'd1);
        req = 8'h00;
        repeat (2) @(negedge clk);

        // Asynchronous reset while 4 holds
        drive(8'h10);
        wait_grant();
        check("areset_pre_id", gnt_id, 3'd4);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("areset_gnt", gnt, 8'h00);
        check("areset_valid", gnt_valid, 1'b0);
        check("areset_id", gnt_id, 3'd0);
        req = 8'hFF;
        @(negedge clk);
        grant_log.delete();
        #1 rst = 1'b0;
        wait_grant();
        check("areset_first_after", gnt_id, 3'd0);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            rst = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        #1 begin
            rst = 1'b0;
            req = 8'h00;
        end
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
